// File: rtl/gray_pkg.sv
// ============================================================================
// Module   : gray_pkg
// Brief    : Shared encodings and helpers for the gray-code monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gray_pkg;

    localparam int DEFAULT_WIDTH = 3;

    localparam logic [1:0] GM_IDLE  = 2'd0;
    localparam logic [1:0] GM_TRACK = 2'd1;
    localparam logic [1:0] GM_ERROR = 2'd2;

    function automatic logic [DEFAULT_WIDTH-1:0] gray2bin(input logic [DEFAULT_WIDTH-1:0] g);
        logic [DEFAULT_WIDTH-1:0] b;
        b[DEFAULT_WIDTH-1] = g[DEFAULT_WIDTH-1];
        for (int i = DEFAULT_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_to_bin.sv
// ============================================================================
// Module   : gray_to_bin
// Brief    : Purely combinational gray-to-binary converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the parity of the gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

`default_nettype wire

// File: rtl/gray_monitor.sv
// ============================================================================
// Module   : gray_monitor
// Brief    : Checks a gray counter stream for legal +1 steps, counts wraps.
//            Optional overflow-flag checking under GRAY_MON_OVF_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Sample_En,
    input  logic              Clear,
    input  logic [WIDTH-1:0]  Gray_In,
    input  logic              Overflow_In,
    output logic [WIDTH-1:0]  Binary,
    output logic              Valid,
    output logic [WRAP_W-1:0] Wrap_Count,
    output logic              Wrap_Sat,
    output logic              Step_Err
`ifdef GRAY_MON_OVF_CHECK_EN
    ,
    output logic              Ovf_Err
`endif
);

    localparam logic [WIDTH-1:0]  BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  BIN_MAX  = {WIDTH{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] bin_inc;
    logic             is_hold;
    logic             is_step;
    logic             is_wrap;
    logic             ovf_fault;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .gray (Gray_In),
        .bin  (new_bin)
    );

    assign bin_inc  = Binary + BIN_ONE;
    assign is_hold  = (new_bin == Binary);
    assign is_step  = (new_bin == bin_inc);
    assign is_wrap  = is_step && (Binary == BIN_MAX);
    assign Wrap_Sat = &Wrap_Count;

`ifdef GRAY_MON_OVF_CHECK_EN
    // A wrap must coincide with the counter's overflow flag; the flag must
    // not be seen before the first wrap.
    assign ovf_fault = is_wrap ? !Overflow_In
                               : (Overflow_In && (Wrap_Count == '0));
`else
    logic unused_ovf;
    assign unused_ovf = Overflow_In;
    assign ovf_fault  = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= GM_IDLE;
            Binary     <= '0;
            Valid      <= 1'b0;
            Wrap_Count <= '0;
            Step_Err   <= 1'b0;
`ifdef GRAY_MON_OVF_CHECK_EN
            Ovf_Err    <= 1'b0;
`endif
        end else if (Clear) begin
            state      <= GM_IDLE;
            Valid      <= 1'b0;
            Wrap_Count <= '0;
            Step_Err   <= 1'b0;
`ifdef GRAY_MON_OVF_CHECK_EN
            Ovf_Err    <= 1'b0;
`endif
        end else if (state == 2'd3) begin
            state <= GM_IDLE;
        end else if (Sample_En) begin
            case (state)
                GM_IDLE: begin
                    Binary <= new_bin;
                    Valid  <= 1'b1;
                    state  <= GM_TRACK;
                end
                GM_TRACK: begin
                    if (ovf_fault) begin
`ifdef GRAY_MON_OVF_CHECK_EN
                        Ovf_Err <= 1'b1;
`endif
                        Binary  <= new_bin;
                        state   <= GM_ERROR;
                    end else if (is_hold) begin
                        Binary <= Binary;
                    end else if (is_step) begin
                        Binary <= new_bin;
                        if (is_wrap && !Wrap_Sat) begin
                            Wrap_Count <= Wrap_Count + WRAP_ONE;
                        end
                    end else begin
                        Step_Err <= 1'b1;
                        Binary   <= new_bin;
                        state    <= GM_ERROR;
                    end
                end
                GM_ERROR: begin
                    Binary <= new_bin;
                end
                default: begin
                    state <= GM_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gray_monitor.sv
// ============================================================================
// Module   : tb_gray_monitor
// Brief    : Self-checking bench for gray_monitor (WRAP_W=8 and WRAP_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Sample_En = 1'b0;
    logic       Clear = 1'b0;
    logic       Overflow_In = 1'b0;
    logic [2:0] Gray_In = 3'd0;

    logic [2:0] bin_a, bin_b;
    logic       valid_a, valid_b, sat_a, sat_b, err_a, err_b;
    logic [7:0] wc_a;
    logic [1:0] wc_b;
`ifdef GRAY_MON_OVF_CHECK_EN
    logic       oerr_a, oerr_b;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: binary value, mode 0=waiting for first sample,
    // 1=tracking, 2=faulted.
    int m_bin, m_mode, m_wc8, m_wc2;
    bit m_valid, m_err, m_oerr;

    always #5 Clk = ~Clk;

    gray_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Sample_En   (Sample_En),
        .Clear       (Clear),
        .Gray_In     (Gray_In),
        .Overflow_In (Overflow_In),
        .Binary      (bin_a),
        .Valid       (valid_a),
        .Wrap_Count  (wc_a),
        .Wrap_Sat    (sat_a),
        .Step_Err    (err_a)
`ifdef GRAY_MON_OVF_CHECK_EN
        ,
        .Ovf_Err     (oerr_a)
`endif
    );

    gray_monitor #(.WIDTH(3), .WRAP_W(2)) dut_w2 (
        .Clk         (Clk),
        .Reset       (Reset),
        .Sample_En   (Sample_En),
        .Clear       (Clear),
        .Gray_In     (Gray_In),
        .Overflow_In (Overflow_In),
        .Binary      (bin_b),
        .Valid       (valid_b),
        .Wrap_Count  (wc_b),
        .Wrap_Sat    (sat_b),
        .Step_Err    (err_b)
`ifdef GRAY_MON_OVF_CHECK_EN
        ,
        .Ovf_Err     (oerr_b)
`endif
    );

    function automatic logic [2:0] to_gray(input int b);
        logic [2:0] v;
        v = b[2:0];
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        m_bin = 0; m_mode = 0; m_wc8 = 0; m_wc2 = 0;
        m_valid = 0; m_err = 0; m_oerr = 0;
    endtask

    task automatic model_edge(input bit en, input bit clr, input int b, input bit ovf);
        bit wrap;
        bit fault;
        wrap  = (m_bin == 7) && (b == 0);
        fault = 1'b0;
`ifdef GRAY_MON_OVF_CHECK_EN
        fault = wrap ? !ovf : (ovf && m_wc8 == 0);
`else
        if (ovf && 1'b0) fault = 1'b1;
`endif
        if (clr) begin
            m_mode = 0; m_valid = 0; m_err = 0; m_wc8 = 0; m_wc2 = 0; m_oerr = 0;
        end else if (en) begin
            if (m_mode == 0) begin
                m_bin = b; m_valid = 1; m_mode = 1;
            end else if (m_mode == 2) begin
                m_bin = b;
            end else if (fault) begin
                m_oerr = 1; m_mode = 2; m_bin = b;
            end else if (b == m_bin) begin
                m_mode = 1;
            end else if (b == (m_bin + 1) % 8) begin
                if (wrap) begin
                    m_wc8 = (m_wc8 < 255) ? m_wc8 + 1 : 255;
                    m_wc2 = (m_wc2 < 3) ? m_wc2 + 1 : 3;
                end
                m_bin = b;
            end else begin
                m_err = 1; m_mode = 2; m_bin = b;
            end
        end
    endtask

    // Drive one clock cycle of inputs, advance the model, settle past the edge.
    task automatic cyc(input bit en, input bit clr, input int b, input bit ovf);
        Sample_En   = en;
        Clear       = clr;
        Gray_In     = to_gray(b);
        Overflow_In = ovf;
        @(posedge Clk);
        model_edge(en, clr, b, ovf);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if ({bin_a, valid_a, wc_a, sat_a, err_a} !== 14'd0) begin
            bad++; $display("FAIL reset_a got=%h want=0", {bin_a, valid_a, wc_a, sat_a, err_a});
        end
        total++;
        if ({bin_b, valid_b, wc_b, sat_b, err_b} !== 8'd0) begin
            bad++; $display("FAIL reset_b got=%h want=0", {bin_b, valid_b, wc_b, sat_b, err_b});
        end
        Reset = 1'b1;
        cyc(0, 0, 5, 0);
        total++;
        if (valid_a !== 1'b0 || bin_a !== 3'd0) begin
            bad++; $display("FAIL idle_no_sample valid=%b bin=%0d want 0/0", valid_a, bin_a);
        end
        cyc(1, 0, 0, 0);
        total++;
        if (valid_a !== 1'b1 || bin_a !== 3'd0) begin
            bad++; $display("FAIL first_sample valid=%b bin=%0d want 1/0", valid_a, bin_a);
        end
    endtask

    task automatic test_legal_sequence();
        int seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        foreach (seq[i]) begin
            cyc(1, 0, seq[i], seq[i] == 0);
            total++;
            if (bin_a !== 3'(seq[i]) || err_a !== 1'b0) begin
                bad++; $display("FAIL legal_step%0d bin=%0d err=%b want %0d/0", i, bin_a, err_a, seq[i]);
            end
        end
        total++;
        if (wc_a !== 8'd1 || wc_b !== 2'd1 || sat_a !== 1'b0) begin
            bad++; $display("FAIL legal_wrap wc_a=%0d wc_b=%0d sat=%b want 1/1/0", wc_a, wc_b, sat_a);
        end
    endtask

    task automatic test_step_error();
        cyc(1, 0, 1, 1);
        cyc(1, 0, 2, 1);
        total++;
        if (bin_a !== 3'd2 || err_a !== 1'b0) begin
            bad++; $display("FAIL pre_err bin=%0d err=%b want 2/0", bin_a, err_a);
        end
        cyc(1, 0, 6, 1);
        total++;
        if (err_a !== 1'b1 || err_b !== 1'b1 || bin_a !== 3'd6) begin
            bad++; $display("FAIL step_err err=%b/%b bin=%0d want 1/1/6", err_a, err_b, bin_a);
        end
        cyc(1, 0, 7, 1);
        cyc(1, 0, 0, 1);
        total++;
        if (wc_a !== 8'd1 || err_a !== 1'b1 || bin_a !== 3'd0) begin
            bad++; $display("FAIL err_frozen wc=%0d err=%b bin=%0d want 1/1/0", wc_a, err_a, bin_a);
        end
        cyc(0, 1, 5, 0);
        total++;
        if (err_a !== 1'b0 || valid_a !== 1'b0 || wc_a !== 8'd0 || bin_a !== 3'd0) begin
            bad++; $display("FAIL clear err=%b valid=%b wc=%0d bin=%0d want 0/0/0/0",
                            err_a, valid_a, wc_a, bin_a);
        end
    endtask

    task automatic test_wrap_sat();
        cyc(1, 0, 0, 0);
        for (int w = 1; w <= 4; w++) begin
            for (int b = 1; b <= 8; b++) cyc(1, 0, b % 8, b == 8 || w > 1);
            total++;
            if (wc_b !== 2'((w > 3) ? 3 : w) || sat_b !== (w >= 3) || wc_a !== 8'(w)) begin
                bad++; $display("FAIL wrap_sat%0d wc_b=%0d sat_b=%b wc_a=%0d want %0d/%0d/%0d",
                                w, wc_b, sat_b, wc_a, (w > 3) ? 3 : w, w >= 3, w);
            end
        end
    endtask

    task automatic test_clear_collision();
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        total++;
        if (valid_a !== 1'b0 || bin_a !== 3'd0) begin
            bad++; $display("FAIL clear_wins valid=%b bin=%0d want 0/0", valid_a, bin_a);
        end
        cyc(1, 0, 3, 0);
        total++;
        if (valid_a !== 1'b1 || bin_a !== 3'd3 || err_a !== 1'b0) begin
            bad++; $display("FAIL idle_after_clear valid=%b bin=%0d err=%b want 1/3/0", valid_a, bin_a, err_a);
        end
    endtask

    task automatic test_async_reset();
        int seq[6] = '{4, 5, 6, 7, 0, 1};
        foreach (seq[i]) cyc(1, 0, seq[i], seq[i] <= 1);
        total++;
        if (bin_a !== 3'd1 || wc_a !== 8'd1) begin
            bad++; $display("FAIL pre_async bin=%0d wc=%0d want 1/1", bin_a, wc_a);
        end
        #3;
        Reset = 1'b0;
        #1;
        total++;
        if ({bin_a, valid_a, wc_a, sat_a, err_a} !== 14'd0) begin
            bad++; $display("FAIL async_reset got=%h want=0", {bin_a, valid_a, wc_a, sat_a, err_a});
        end
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit en, clr, ovf;
            int r, b;
            en  = ($urandom % 4) != 0;
            clr = ($urandom % 40) == 0;
            r   = $urandom % 16;
            if (r < 10)      b = (m_bin + 1) % 8;
            else if (r < 15) b = m_bin;
            else             b = $urandom % 8;
            ovf = (m_wc8 > 0) || (m_bin == 7 && b == 0) || (($urandom % 32) == 0);
            cyc(en, clr, b, ovf);
            total++;
            if ({bin_a, valid_a, wc_a, sat_a, err_a} !==
                {3'(m_bin), m_valid, 8'(m_wc8), m_wc8 == 255, m_err}) begin
                bad++; $display("FAIL random_a cyc=%0d got=%h want=%h", n,
                                {bin_a, valid_a, wc_a, sat_a, err_a},
                                {3'(m_bin), m_valid, 8'(m_wc8), m_wc8 == 255, m_err});
            end
            total++;
            if ({bin_b, valid_b, wc_b, sat_b, err_b} !==
                {3'(m_bin), m_valid, 2'(m_wc2), m_wc2 == 3, m_err}) begin
                bad++; $display("FAIL random_b cyc=%0d got=%h want=%h", n,
                                {bin_b, valid_b, wc_b, sat_b, err_b},
                                {3'(m_bin), m_valid, 2'(m_wc2), m_wc2 == 3, m_err});
            end
`ifdef GRAY_MON_OVF_CHECK_EN
            total++;
            if (oerr_a !== m_oerr || oerr_b !== m_oerr) begin
                bad++; $display("FAIL random_ovf cyc=%0d got=%b/%b want=%b", n, oerr_a, oerr_b, m_oerr);
            end
`endif
        end
    endtask

`ifdef GRAY_MON_OVF_CHECK_EN
    task automatic test_ovf();
        cyc(0, 1, 0, 0);
        for (int b = 0; b <= 8; b++) cyc(1, 0, b % 8, 0);
        total++;
        if (oerr_a !== 1'b1 || err_a !== 1'b0 || wc_a !== 8'd0) begin
            bad++; $display("FAIL ovf_missing oerr=%b err=%b wc=%0d want 1/0/0", oerr_a, err_a, wc_a);
        end
        cyc(0, 1, 0, 0);
        for (int b = 0; b <= 8; b++) cyc(1, 0, b % 8, b == 8);
        total++;
        if (oerr_a !== 1'b0 || wc_a !== 8'd1) begin
            bad++; $display("FAIL ovf_ok oerr=%b wc=%0d want 0/1", oerr_a, wc_a);
        end
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 1);
        total++;
        if (oerr_a !== 1'b1) begin
            bad++; $display("FAIL ovf_early oerr=%b want 1", oerr_a);
        end
        cyc(0, 1, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_legal_sequence();
        test_step_error();
        test_wrap_sat();
        test_clear_collision();
        test_async_reset();
`ifdef GRAY_MON_OVF_CHECK_EN
        test_ovf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
